// File: rtl/mudi_issue.sv
// mudi_issue: E-stage issue register and D-stage interlock for the multiply/divide unit.
// Latency: D to E is one cycle; start/We are combinational from the E register and last one cycle.
// Backpressure: stall_D freezes D while an op is being issued or the unit reports buzy; stall_other/exp_in insert bubbles.
//
// Ports:
//   Clk, Reset                 clock and synchronous active-high reset
//   D_valid, D_MuDiOp          multiply/divide-class instruction waiting in D and its op
//   D_rs, D_rt                 forwarded operands of that instruction
//   stall_other                hazard unit freezes D for a reason unrelated to this unit
//   exp_in                     exception/flush, also seen by the multiply/divide unit
//   buzy                       multiply/divide unit is computing
//   MuDiOp, A, B, Din          E-stage op and operands presented to the unit (Din mirrors A)
//   start, We                  E op is mult/multu/div/divu, or mthi/mtlo
//   stall_D                    freeze D and PC, bubble into E
//   stall_cnt                  free-running count of stall_D cycles (wraps)

// Op encodings normally come from header.v; these fallbacks keep the file
// self-contained. A bubble shares the mult code: the unit only acts on start
// and We, and both are gated by the E valid bit, so the alias is harmless.
`ifndef MUDI_MULT
`define MUDI_MULT  3'd0
`endif
`ifndef MUDI_MULTU
`define MUDI_MULTU 3'd1
`endif
`ifndef MUDI_DIV
`define MUDI_DIV   3'd2
`endif
`ifndef MUDI_DIVU
`define MUDI_DIVU  3'd3
`endif
`ifndef MUDI_MTHI
`define MUDI_MTHI  3'd4
`endif
`ifndef MUDI_MTLO
`define MUDI_MTLO  3'd5
`endif
`ifndef MUDI_MFHI
`define MUDI_MFHI  3'd6
`endif
`ifndef MUDI_MFLO
`define MUDI_MFLO  3'd7
`endif
`ifndef MUDI_NONE
`define MUDI_NONE  3'd0
`endif

module mudi_issue (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        D_valid,
  input  logic [2:0]  D_MuDiOp,
  input  logic [31:0] D_rs,
  input  logic [31:0] D_rt,
  input  logic        stall_other,
  input  logic        exp_in,
  input  logic        buzy,
  output logic [2:0]  MuDiOp,
  output logic [31:0] A,
  output logic [31:0] B,
  output logic [31:0] Din,
  output logic        start,
  output logic        We,
  output logic        stall_D,
  output logic [31:0] stall_cnt
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUED = 2'd1,
    S_BUSY   = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        e_valid_q, e_valid_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] cnt_q, cnt_d;
  logic        is_md, is_mt, occupied;

  assign is_md = (op_q == `MUDI_MULT) || (op_q == `MUDI_MULTU) ||
                 (op_q == `MUDI_DIV)  || (op_q == `MUDI_DIVU);
  assign is_mt = (op_q == `MUDI_MTHI) || (op_q == `MUDI_MTLO);

  assign MuDiOp    = op_q;
  assign A         = a_q;
  assign B         = b_q;
  assign Din       = a_q;
  assign start     = e_valid_q & is_md;
  assign We        = e_valid_q & is_mt;
  assign stall_cnt = cnt_q;

  // The tracker state lags buzy by one edge, so its contribution is qualified
  // by the live buzy: otherwise the cycle after the unit drops buzy (or the
  // cycle after a divide-by-zero start) would stall D for no reason.
  assign occupied = start | buzy | ((state_q != S_IDLE) & buzy);
  assign stall_D  = D_valid & ~exp_in & occupied;

  always_comb begin
    state_d   = state_q;
    e_valid_d = e_valid_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    cnt_d     = cnt_q;

    // E register: flush, bubble while D is held, otherwise take D.
    if (exp_in || stall_D || stall_other) begin
      e_valid_d = 1'b0;
      op_d      = `MUDI_NONE;
      a_d       = 32'd0;
      b_d       = 32'd0;
    end else begin
      e_valid_d = D_valid;
      op_d      = D_valid ? D_MuDiOp : `MUDI_NONE;
      a_d       = D_rs;
      b_d       = D_rt;
    end

    // Occupancy tracker: ISSUED is the cycle where the unit first reacts to
    // start; buzy=0 there means it declined (divide by zero).
    case (state_q)
      S_IDLE:   if (start) state_d = S_ISSUED;
      S_ISSUED: state_d = buzy ? S_BUSY : S_IDLE;
      S_BUSY:   if (!buzy) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    // The unit aborts its op on exp_in, so nothing is left in flight.
    if (exp_in) state_d = S_IDLE;

    if (stall_D) cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      e_valid_q <= 1'b0;
      op_q      <= `MUDI_NONE;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      cnt_q     <= 32'd0;
    end else begin
      state_q   <= state_d;
      e_valid_q <= e_valid_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule
